// File: rtl/fifo_sched_pkg.sv
// Shared constants and FSM encoding for the class-FIFO round-robin scheduler.
package fifo_sched_pkg;

  localparam int NUM_Q     = 4;
  localparam int DATA_SIZE = 6;
  localparam int GID_W     = 2;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: first requester at or after the pointer wins,
// and the pointer moves past the winner only when the grant is accepted.
module rr_arbiter4 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       accept,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_vld
);

  logic [1:0] ptr_q, ptr_d;
  logic [1:0] cand;

  // Scan the four positions starting from the pointer, wrapping 3 -> 0.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    grant = grant_vld ? (4'b0001 << grant_idx) : 4'b0000;
    ptr_d = (accept && grant_vld) ? grant_idx + 2'd1 : ptr_q;
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 2'd0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Drains four class FIFOs round-robin into one destination FIFO, owns the
// shared almost-full/almost-empty thresholds and a small control FSM.
module fifo_rr_scheduler #(
  parameter int DATA_SIZE = fifo_sched_pkg::DATA_SIZE,
  parameter int NUM_Q     = fifo_sched_pkg::NUM_Q
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [DATA_SIZE-1:0]       umb_almost_full_cfg,
  input  logic [DATA_SIZE-1:0]       umb_almost_empty_cfg,
  input  logic [NUM_Q-1:0]           src_empty,
  input  logic [NUM_Q-1:0]           src_error,
  input  logic [NUM_Q*DATA_SIZE-1:0] src_data,
  input  logic                       dst_pause,
  input  logic                       dst_error,
  output logic [DATA_SIZE-1:0]       umb_almost_full,
  output logic [DATA_SIZE-1:0]       umb_almost_empty,
  output logic [NUM_Q-1:0]           pop,
  output logic                       push,
  output logic [DATA_SIZE-1:0]       data_out,
  output logic [1:0]                 grant_id,
  output logic                       idle,
  output logic                       error_out
);
  import fifo_sched_pkg::*;

  state_e               state_q, state_d;
  logic [DATA_SIZE-1:0] thr_full_q, thr_full_d;
  logic [DATA_SIZE-1:0] thr_empty_q, thr_empty_d;
  // [1]: word requested last cycle, now on src_data; [2]: word on data_out.
  logic [2:1]           vld_pipe_q, vld_pipe_d;
  logic [1:0]           s1_id_q, s1_id_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic [1:0]           gid_q, gid_d;
  logic                 idle_q, idle_d;
  logic                 err_q, err_d;

  logic       err_in;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       pop_fire;
  logic       drained;

  // Eligibility is gated by state and back-pressure; errors and reset veto the pop.
  always_comb begin
    err_in   = (|src_error) | dst_error;
    req      = (state_q == ST_ACTIVE && !dst_pause) ? ~src_empty : 4'b0000;
    pop_fire = gnt_vld && !err_in && !reset && (state_q == ST_ACTIVE);
    pop      = pop_fire ? gnt : 4'b0000;
    drained  = ~|vld_pipe_q;
  end

  rr_arbiter4 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .accept    (pop_fire),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_vld (gnt_vld)
  );

  // Control FSM next state and threshold loading.
  always_comb begin
    state_d     = state_q;
    thr_full_d  = thr_full_q;
    thr_empty_d = thr_empty_q;
    if (state_q == ST_RESET) begin
      state_d = ST_INIT;
    end else if (err_in) begin
      state_d = ST_ERROR;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (init) begin
            thr_full_d  = umb_almost_full_cfg;
            thr_empty_d = umb_almost_empty_cfg;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (init)                            state_d = ST_INIT;
          else if (!(&src_empty) && !dst_pause) state_d = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if ((&src_empty) && drained) state_d = ST_IDLE;
        end
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_RESET;
      endcase
    end
    idle_d = (state_d == ST_IDLE);
    err_d  = (state_d == ST_ERROR);
  end

  // Two-stage datapath: capture the source word the cycle after the pop, push it the next.
  always_comb begin
    vld_pipe_d[1] = pop_fire;
    vld_pipe_d[2] = vld_pipe_q[1];
    s1_id_d       = gnt_idx;
    data_d        = data_q;
    gid_d         = gid_q;
    if (vld_pipe_q[1]) begin
      data_d = src_data[int'(s1_id_q)*DATA_SIZE +: DATA_SIZE];
      gid_d  = s1_id_q;
    end
  end

  // State, thresholds and pipeline registers; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RESET;
      thr_full_q  <= '0;
      thr_empty_q <= '0;
      vld_pipe_q  <= '0;
      s1_id_q     <= '0;
      data_q      <= '0;
      gid_q       <= '0;
      idle_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      thr_full_q  <= thr_full_d;
      thr_empty_q <= thr_empty_d;
      vld_pipe_q  <= vld_pipe_d;
      s1_id_q     <= s1_id_d;
      data_q      <= data_d;
      gid_q       <= gid_d;
      idle_q      <= idle_d;
      err_q       <= err_d;
    end
  end

  assign umb_almost_full  = thr_full_q;
  assign umb_almost_empty = thr_empty_q;
  assign push             = vld_pipe_q[2];
  assign data_out         = data_q;
  assign grant_id         = gid_q;
  assign idle             = idle_q;
  assign error_out        = err_q;

endmodule
